// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble datapath controller: opcode values,
// controller state encoding and the Moore output decode.
package nibble_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JZ  = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_DECODE = 3'd3,
        ST_OPRD   = 3'd4,
        ST_EXEC   = 3'd5,
        ST_JUMP   = 3'd6,
        ST_HALT   = 3'd7
    } ctrl_state_t;

    // Strobe bundle produced for one controller state.
    typedef struct packed {
        logic mem_req;
        logic ir_en;
        logic pc_en;
        logic pc_load;
        logic acc_en;
        logic acc_sel;
        logic busy;
        logic halted;
    } ctrl_out_t;

    // True in the states that hold an outstanding memory request.
    function automatic logic is_mem_state(input ctrl_state_t s);
        return (s == ST_FETCH) || (s == ST_OPRD);
    endfunction

    // Strobes for a state; only EXEC looks at the opcode (LDA/ADD write the
    // accumulator, anything else reaching EXEC just skips the operand).
    function automatic ctrl_out_t decode_outputs(input ctrl_state_t s, input logic [3:0] op);
        ctrl_out_t o;
        o = '0;
        case (s)
            ST_IDLE: begin
                o = '0;
            end
            ST_FETCH, ST_OPRD: begin
                o.mem_req = 1'b1;
                o.busy    = 1'b1;
            end
            ST_LATCH: begin
                o.ir_en = 1'b1;
                o.pc_en = 1'b1;
                o.busy  = 1'b1;
            end
            ST_DECODE: begin
                o.busy = 1'b1;
            end
            ST_EXEC: begin
                o.pc_en   = 1'b1;
                o.acc_en  = (op == OP_LDA) || (op == OP_ADD);
                o.acc_sel = (op == OP_ADD);
                o.busy    = 1'b1;
            end
            ST_JUMP: begin
                o.pc_load = 1'b1;
                o.busy    = 1'b1;
            end
            ST_HALT: begin
                o.halted = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/nibble_ctrl_wait_timer.sv
// Bounded-wait counter for memory requests. Held at zero while clr is high,
// counts while en is high, and flags when the count has reached WAIT_MAX.
module wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [3:0] LIMIT = 4'(WAIT_MAX);

    logic [3:0] count_r;

    // Wait cycle counter: clear has priority over counting.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            count_r <= 4'd0;
        end else if (clr) begin
            count_r <= 4'd0;
        end else if (en) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/nibble_ctrl.sv
// Fetch/decode/execute sequencer for the nibble datapath. Owns every
// architectural register strobe; outputs are registered decodes of the
// next state so they are clean and drop to zero the moment Rst falls.
module nibble_ctrl
    import nibble_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       mem_ready,
    input  logic [3:0] opcode,
    input  logic       zero,
    output logic       mem_req,
    output logic       ir_en,
    output logic       pc_en,
    output logic       pc_load,
    output logic       acc_en,
    output logic       acc_sel,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    ctrl_state_t state_r;
    ctrl_state_t next_state_s;
    ctrl_out_t   out_r;
    logic        err_r;
    logic        mem_wait_s;
    logic        expired_s;
    logic        timeout_s;

    assign mem_wait_s = is_mem_state(state_r);
    // A ready in the limit cycle wins over the timeout.
    assign timeout_s  = mem_wait_s && expired_s && !mem_ready;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .Rst     (Rst),
        .clr     (!mem_wait_s),
        .en      (mem_wait_s && !mem_ready),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    next_state_s = ST_LATCH;
                end else if (timeout_s) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_LATCH: begin
                next_state_s = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD: next_state_s = ST_OPRD;
                    OP_JMP:         next_state_s = ST_JUMP;
                    OP_JZ: begin
                        if (zero) begin
                            next_state_s = ST_JUMP;
                        end else begin
                            next_state_s = ST_EXEC;
                        end
                    end
                    OP_HLT:         next_state_s = ST_HALT;
                    default:        next_state_s = ST_FETCH;
                endcase
            end
            ST_OPRD: begin
                if (mem_ready) begin
                    next_state_s = ST_EXEC;
                end else if (timeout_s) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_OPRD;
                end
            end
            ST_EXEC: begin
                next_state_s = ST_FETCH;
            end
            ST_JUMP: begin
                next_state_s = ST_FETCH;
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output register: strobes for the state being entered.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            out_r <= '0;
        end else begin
            out_r <= decode_outputs(next_state_s, opcode);
        end
    end

    // Sticky timeout fault, cleared only by reset.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | timeout_s;
        end
    end

    assign mem_req = out_r.mem_req;
    assign ir_en   = out_r.ir_en;
    assign pc_en   = out_r.pc_en;
    assign pc_load = out_r.pc_load;
    assign acc_en  = out_r.acc_en;
    assign acc_sel = out_r.acc_sel;
    assign busy    = out_r.busy;
    assign halted  = out_r.halted;
    assign err     = err_r;

endmodule

// File: tb/tb_nibble_ctrl.sv
// Scoreboard bench for nibble_ctrl: a per-instruction reference model emits
// the input stimulus and the expected strobe vector for every cycle; a
// driver plays the stimulus and a monitor compares the outputs.
module tb_nibble_ctrl;

    localparam int WMAX = 3;

    localparam int PH_FETCH  = 0;
    localparam int PH_LATCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_OPRD   = 3;
    localparam int PH_EXEC   = 4;
    localparam int PH_JUMP   = 5;
    localparam int PH_HALT   = 6;

    logic       clk       = 1'b0;
    logic       Rst       = 1'b0;
    logic       start     = 1'b1;
    logic       mem_ready = 1'b0;
    logic [3:0] opcode    = 4'h0;
    logic       zero      = 1'b0;
    logic       mem_req, ir_en, pc_en, pc_load, acc_en, acc_sel, busy, halted, err;

    typedef struct packed {
        logic       start;
        logic       mem_ready;
        logic       zero;
        logic [3:0] opcode;
    } stim_t;

    stim_t      stim_q[$];
    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    nibble_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk(clk), .Rst(Rst), .start(start), .mem_ready(mem_ready),
        .opcode(opcode), .zero(zero), .mem_req(mem_req), .ir_en(ir_en),
        .pc_en(pc_en), .pc_load(pc_load), .acc_en(acc_en), .acc_sel(acc_sel),
        .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {mem_req, ir_en, pc_en, pc_load, acc_en, acc_sel, busy, halted, err};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (req,ir,pc,pcl,acc,sel,busy,halt,err) at %0t",
                     name, got, expv, $time);
        end
    endtask

    // Expected strobes for one cycle of a given phase.
    function automatic logic [8:0] pv(input int ph, input bit acc, input bit sel, input bit e);
        case (ph)
            PH_FETCH, PH_OPRD: pv = 9'b100000100;
            PH_LATCH:          pv = 9'b011000100;
            PH_DECODE:         pv = 9'b000000100;
            PH_EXEC:           pv = {1'b0, 1'b0, 1'b1, 1'b0, acc, sel, 1'b1, 1'b0, 1'b0};
            PH_JUMP:           pv = 9'b000100100;
            PH_HALT:           pv = {7'b0000000, 1'b1, e};
            default:           pv = 9'b000000000;
        endcase
    endfunction

    task automatic push(input bit rdy, input bit z, input logic [3:0] op, input logic [8:0] e);
        stim_t s;
        s.start     = 1'($urandom_range(0, 1));
        s.mem_ready = rdy;
        s.zero      = z;
        s.opcode    = op;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic gen_halt(input bit e);
        for (int k = 0; k < 4; k++)
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 pv(PH_HALT, 1'b0, 1'b0, e));
    endtask

    // A memory phase with w wait cycles; w > WMAX means it never answers in time.
    task automatic gen_mem(input int ph, input int w, input bit z, input logic [3:0] op, output bit timed_out);
        timed_out = (w > WMAX);
        if (timed_out) begin
            for (int k = 0; k <= WMAX; k++) push(1'b0, z, op, pv(ph, 1'b0, 1'b0, 1'b0));
            gen_halt(1'b1);
        end else begin
            for (int k = 0; k < w; k++) push(1'b0, z, op, pv(ph, 1'b0, 1'b0, 1'b0));
            push(1'b1, z, op, pv(ph, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // One whole instruction; ended is set when the program cannot continue.
    task automatic gen_instr(input logic [3:0] op, input bit z, input int wf, input int wo, output bit ended);
        bit to;
        ended = 1'b0;
        gen_mem(PH_FETCH, wf, z, 4'($urandom_range(0, 15)), to);
        if (to) begin
            ended = 1'b1;
        end else begin
            push(1'($urandom_range(0, 1)), z, op, pv(PH_LATCH, 1'b0, 1'b0, 1'b0));
            push(1'($urandom_range(0, 1)), z, op, pv(PH_DECODE, 1'b0, 1'b0, 1'b0));
            if (op == 4'h1 || op == 4'h2) begin
                gen_mem(PH_OPRD, wo, z, op, to);
                if (to) ended = 1'b1;
                else push(1'($urandom_range(0, 1)), z, op, pv(PH_EXEC, 1'b1, op == 4'h2, 1'b0));
            end else if (op == 4'h3 || (op == 4'h4 && z)) begin
                push(1'($urandom_range(0, 1)), z, op, pv(PH_JUMP, 1'b0, 1'b0, 1'b0));
            end else if (op == 4'h4) begin
                push(1'($urandom_range(0, 1)), z, op, pv(PH_EXEC, 1'b0, 1'b0, 1'b0));
            end else if (op == 4'hF) begin
                gen_halt(1'b0);
                ended = 1'b1;
            end
        end
    endtask

    // Driver: plays the planned inputs; idles with start high.
    always @(negedge clk) begin
        stim_t s;
        if (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            start = s.start; mem_ready = s.mem_ready; zero = s.zero; opcode = s.opcode;
        end else begin
            start = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 4'h0;
        end
    end

    // Monitor: compares every planned cycle against the DUT outputs.
    always @(negedge clk) begin
        logic [8:0] e;
        if (Rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            check($sformatf("cycle%0d", cyc), outs(), e);
        end
    end

    task automatic begin_session();
        @(negedge clk);
        #2;
        Rst = 1'b1;
    endtask

    task automatic end_session(input string name);
        int budget = 0;
        while (exp_q.size() > 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL %s_drain: %0d expected cycles left unchecked, required 0", name, exp_q.size());
        end
        Rst = 1'b0;
        #1;
        check({name, "_reset"}, outs(), 9'b0);
        stim_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit ended;
        int r;
        logic [3:0] op;

        // Reset held with start high: everything stays low.
        repeat (2) @(negedge clk);
        #1;
        check("reset_held", outs(), 9'b0);

        // NOP stream with zero-wait memory, then halt (start ignored in HALT).
        begin_session();
        for (int i = 0; i < 3; i++) gen_instr(4'h0, 1'b0, 0, 0, ended);
        gen_instr(4'hF, 1'b0, 0, 0, ended);
        end_session("nop");

        // ADD with one wait cycle per request.
        begin_session();
        gen_instr(4'h2, 1'b0, 1, 1, ended);
        gen_instr(4'hF, 1'b0, 0, 0, ended);
        end_session("add_wait");

        // Branches, load and an undefined opcode.
        begin_session();
        gen_instr(4'h4, 1'b1, 0, 0, ended);
        gen_instr(4'h4, 1'b0, 0, 0, ended);
        gen_instr(4'h3, 1'b0, 0, 0, ended);
        gen_instr(4'h1, 1'b1, 0, 0, ended);
        gen_instr(4'h9, 1'b0, 0, 0, ended);
        gen_instr(4'hF, 1'b0, 0, 0, ended);
        end_session("branch");

        // Ready arriving in the limit cycle, then a fetch that times out.
        begin_session();
        gen_instr(4'h1, 1'b0, WMAX, WMAX, ended);
        gen_instr(4'h0, 1'b0, WMAX + 1, 0, ended);
        end_session("timeout");

        // Operand read that times out.
        begin_session();
        gen_instr(4'h2, 1'b0, 0, WMAX + 1, ended);
        end_session("oprd_timeout");

        // Reset asserted while waiting in OPRD.
        begin_session();
        gen_instr(4'h1, 1'b0, 0, 3, ended);
        repeat (5) @(negedge clk);
        #3;
        check("mid_oprd", outs(), pv(PH_OPRD, 1'b0, 1'b0, 1'b0));
        Rst = 1'b0;
        #1;
        check("async_abort", outs(), 9'b0);
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        #1;
        check("abort_held", outs(), 9'b0);

        // Random programs.
        for (int s = 0; s < 20; s++) begin
            begin_session();
            ended = 1'b0;
            for (int i = 0; i < 8 && !ended; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0:       op = 4'h0;
                    1:       op = 4'h1;
                    2, 3:    op = 4'h2;
                    4:       op = 4'h3;
                    5, 6:    op = 4'h4;
                    7:       op = 4'hF;
                    default: op = 4'($urandom_range(5, 14));
                endcase
                gen_instr(op, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 19) == 0) ? WMAX + 1 : $urandom_range(0, WMAX),
                          ($urandom_range(0, 19) == 0) ? WMAX + 1 : $urandom_range(0, WMAX),
                          ended);
            end
            if (!ended) gen_instr(4'hF, 1'b0, 0, 0, ended);
            end_session($sformatf("rand%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
